// File: rtl/cpu_state_sequencer_if.sv
// Interface between the opcode/memory side and the control-unit consumers of the
// CPU state sequencer: opcode and memory handshake in, state, status pulses and counters out.
interface cpu_state_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Opcode;
  logic             mem_ready;
  logic [2:0]       State;
  logic             halted;
  logic             instr_retire;
  logic             illegal_op;
  logic             mem_timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output Opcode, mem_ready,
    input  State, halted, instr_retire, illegal_op, mem_timeout, cycle_count, instr_count
  );

  modport slave (
    input  Opcode, mem_ready,
    output State, halted, instr_retire, illegal_op, mem_timeout, cycle_count, instr_count
  );
endinterface

// File: rtl/cpu_state_sequencer.sv
// Multi-cycle CPU state register and next-state logic with retire/cycle counters,
// halt status and registered illegal-opcode / memory-timeout pulses.
module cpu_state_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                   CLK,
  input logic                   Reset,
  cpu_state_sequencer_if.slave  bus
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    s_if   = 3'b000,
    s_id   = 3'b001,
    s_exe  = 3'b010,
    s_wb   = 3'b011,
    s_mem  = 3'b100,
    s_halt = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    c_alu, c_br, c_jmp, c_lw, c_sw, c_halt, c_bad
  } op_class_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              retire_reg, retire_next;
  logic              illegal_reg, illegal_next;
  logic              timeout_reg, timeout_next;
  logic [CNT_W-1:0]  cycle_reg, instr_reg;
  op_class_t         op_class;

  always_comb begin
    op_class = c_bad;
    case (bus.Opcode)
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
      6'b010010, 6'b011000, 6'b100110, 6'b100111: op_class = c_alu;
      6'b110100, 6'b110101, 6'b110110:            op_class = c_br;
      6'b111000, 6'b111001, 6'b111010:            op_class = c_jmp;
      6'b110001:                                  op_class = c_lw;
      6'b110000:                                  op_class = c_sw;
      6'b111111:                                  op_class = c_halt;
      default:                                    op_class = c_bad;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    retire_next  = 1'b0;
    illegal_next = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      s_if: state_next = s_id;
      s_id: begin
        case (op_class)
          c_jmp: begin
            state_next  = s_if;
            retire_next = 1'b1;
          end
          c_halt: state_next = s_halt;
          c_bad: begin
            state_next   = s_if;
            illegal_next = 1'b1;
          end
          default: state_next = s_exe;
        endcase
      end
      s_exe: begin
        case (op_class)
          c_alu:      state_next = s_wb;
          c_lw, c_sw: state_next = s_mem;
          c_br: begin
            state_next  = s_if;
            retire_next = 1'b1;
          end
          // Opcode is expected stable here; anything else falls back to fetch
          default:    state_next = s_if;
        endcase
      end
      s_mem: begin
        if (bus.mem_ready) begin
          wait_next = '0;
          if (op_class == c_lw) begin
            state_next = s_wb;
          end else if (op_class == c_sw) begin
            state_next  = s_if;
            retire_next = 1'b1;
          end else begin
            state_next = s_if;
          end
        end else if (wait_reg == WAIT_LAST) begin
          // The current cycle is the last allowed MEM cycle: abort without retiring
          wait_next    = '0;
          state_next   = s_if;
          timeout_next = 1'b1;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      s_wb: begin
        state_next  = s_if;
        retire_next = 1'b1;
      end
      s_halt: state_next = s_halt;
      default: state_next = s_if;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_reg   <= s_if;
      wait_reg    <= '0;
      retire_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      timeout_reg <= 1'b0;
      cycle_reg   <= '0;
      instr_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      retire_reg  <= retire_next;
      illegal_reg <= illegal_next;
      timeout_reg <= timeout_next;
      // The edge entering halt still counts; cycles spent in halt do not
      if (state_reg != s_halt) begin
        cycle_reg <= cycle_reg + 1'b1;
      end
      if (retire_next) begin
        instr_reg <= instr_reg + 1'b1;
      end
    end
  end

  assign bus.State        = state_reg;
  assign bus.halted       = (state_reg == s_halt);
  assign bus.instr_retire = retire_reg;
  assign bus.illegal_op   = illegal_reg;
  assign bus.mem_timeout  = timeout_reg;
  assign bus.cycle_count  = cycle_reg;
  assign bus.instr_count  = instr_reg;

endmodule
